// File: rtl/msi_pkg.sv
// Shared definitions for the MSI serial arithmetic blocks: FSM encoding and sizing helper.
package msi_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StShift = SHIFT,
    StDone  = DONE
  } state_t;

  // Bit-counter width for a WIDTH-bit serial operation.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             B_out;
  logic             busy;

  modport master (
    output in_valid, A, B, B_in, out_ready,
    input  in_ready, out_valid, D, B_out, busy
  );

  modport slave (
    input  in_valid, A, B, B_in, out_ready,
    output in_ready, out_valid, D, B_out, busy
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell built from gate primitives.
module full_subtractor (
  input  wire A,
  input  wire B,
  input  wire B_in,
  output wire D,
  output wire B_out
);
  wire w_axb;
  wire w_na;
  wire w_nx;
  wire w_t1;
  wire w_t2;

  xor g_x1 (w_axb, A, B);
  xor g_x2 (D, w_axb, B_in);
  not g_n1 (w_na, A);
  and g_a1 (w_t1, w_na, B);
  not g_n2 (w_nx, w_axb);
  and g_a2 (w_t2, w_nx, B_in);
  or  g_o1 (B_out, w_t1, w_t2);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B - B_in, LSB first, one bit per clock.
module serial_subtractor
  import msi_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_out_valid;
  logic [CntW-1:0]  r_count;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_d_shift;

  full_subtractor u_cell (
    .A     (r_a[0]),
    .B     (r_b[0]),
    .B_in  (r_borrow),
    .D     (w_d),
    .B_out (w_bo)
  );

  // New difference bit enters at the MSB; a 1-bit result is just the cell output.
  if (WIDTH == 1) begin : g_one
    assign w_d_shift = w_d;
  end else begin : g_wide
    assign w_d_shift = {w_d, r_d[WIDTH-1:1]};
  end

  assign bus.in_ready  = rst_n && (r_state == StIdle);
  assign bus.busy      = (r_state == StShift) || (r_state == StDone);
  assign bus.out_valid = r_out_valid;
  assign bus.D         = r_d;
  assign bus.B_out     = r_borrow;

  // Control FSM plus operand, result, borrow and bit-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_borrow    <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= bus.B_in;
            r_d      <= '0;
            r_count  <= '0;
            r_state  <= StShift;
          end
        end
        StShift: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_d      <= w_d_shift;
          r_borrow <= w_bo;
          r_count  <= r_count + CntW'(1);
          if (r_count == LastCnt) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 1, 8 and 13.
module tb_serial_subtractor;

  typedef struct packed {
    logic        bo;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] a_drv [3];
  logic [31:0] b_drv [3];
  logic        bin_drv [3];
  logic        iv_drv [3];
  logic        ordy_drv [3];
  logic [31:0] d_mon [3];
  logic        bo_mon [3];
  logic        ov_mon [3];
  logic        ir_mon [3];
  logic        busy_mon [3];

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 8 : 13);
    serial_subtractor_if #(.WIDTH(W)) bif ();
    assign bif.in_valid  = iv_drv[g];
    assign bif.A         = a_drv[g][W-1:0];
    assign bif.B         = b_drv[g][W-1:0];
    assign bif.B_in      = bin_drv[g];
    assign bif.out_ready = ordy_drv[g];
    assign d_mon[g]      = 32'(bif.D);
    assign bo_mon[g]     = bif.B_out;
    assign ov_mon[g]     = bif.out_valid;
    assign ir_mon[g]     = bif.in_ready;
    assign busy_mon[g]   = bif.busy;
    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
    );
  end

  function automatic int unsigned wid(input int k);
    case (k)
      0:       return 1;
      1:       return 8;
      default: return 13;
    endcase
  endfunction

  // Reference: plain modular arithmetic and an unsigned compare.
  function automatic exp_t model(input int k, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
    exp_t e;
    longint unsigned m  = (64'd1 << wid(k)) - 64'd1;
    longint unsigned av = 64'(a) & m;
    longint unsigned bv = 64'(b) & m;
    longint unsigned bi = 64'(bin);
    e.d  = 32'((av - bv - bi) & m);
    e.bo = (av < bv + bi);
    return e;
  endfunction

  task automatic check(input string name, input int k, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst_w%0d: got 0x%0h required 0x%0h", name, wid(k), act, req);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Inputs are already set for the coming edge; record an acceptance, then advance one cycle.
  task automatic tick(input int k);
    if (rst_n && iv_drv[k] && ir_mon[k])
      q_push(k, model(k, a_drv[k], b_drv[k], bin_drv[k]));
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic bin);
    int n = 0;
    a_drv[k] = a; b_drv[k] = b; bin_drv[k] = bin; iv_drv[k] = 1'b1;
    while (!ir_mon[k] && n < 100) begin
      tick(k);
      n++;
    end
    check("accept_wait", k, longint'(ir_mon[k]), 1);
    tick(k);
    iv_drv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!ir_mon[k] && n < 200) begin
      tick(k);
      n++;
    end
    check("idle_wait", k, longint'(ir_mon[k]), 1);
  endtask

  task automatic rand_run(input int k, input int nops);
    int acc = 0;
    int guard = 0;
    while (acc < nops && guard < 60000) begin
      a_drv[k]    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b_drv[k]    = ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : $urandom;
      bin_drv[k]  = 1'($urandom_range(0, 1));
      iv_drv[k]   = ($urandom_range(0, 3) != 0);
      ordy_drv[k] = ($urandom_range(0, 3) != 0);
      if (iv_drv[k] && ir_mon[k]) acc++;
      tick(k);
      guard++;
    end
    iv_drv[k]   = 1'b0;
    ordy_drv[k] = 1'b1;
    wait_idle(k);
    check("rand_op_count", k, acc, nops);
  endtask

  // Monitor: compares every presented result against the scoreboard and tracks handshakes.
  int   cyc = 0;
  int   acc_cyc [3];
  int   wait_cnt [3];
  logic exp_busy [3];
  logic prev_ov [3];
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          exp_busy[k] = 1'b0;
          prev_ov[k]  = 1'b0;
          wait_cnt[k] = 0;
        end else begin
          check("busy", k, longint'(busy_mon[k]), longint'(exp_busy[k]));
          check("in_ready", k, longint'(ir_mon[k]), longint'(!exp_busy[k]));
          if (ov_mon[k]) begin
            wait_cnt[k] = 0;
            if (!prev_ov[k]) check("latency", k, cyc - acc_cyc[k], wid(k) + 1);
            if (q_size(k) == 0) begin
              check("unexpected_out_valid", k, longint'(ov_mon[k]), 0);
            end else begin
              e = q_front(k);
              check("D", k, d_mon[k], e.d);
              check("B_out", k, longint'(bo_mon[k]), longint'(e.bo));
              if (ordy_drv[k]) q_pop(k);
            end
          end else if (q_size(k) != 0) begin
            wait_cnt[k]++;
            if (wait_cnt[k] > 4 * wid(k) + 20) begin
              check("result_timeout", k, wait_cnt[k], 4 * wid(k) + 20);
              wait_cnt[k] = 0;
            end
          end
          if (iv_drv[k] && ir_mon[k]) begin
            exp_busy[k] = 1'b1;
            acc_cyc[k]  = cyc;
          end
          if (ov_mon[k] && ordy_drv[k]) exp_busy[k] = 1'b0;
          prev_ov[k] = ov_mon[k];
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // Stimulus sequence.
  initial begin
    int stamp [3];
    int nacc;
    int n;
    for (int k = 0; k < 3; k++) begin
      a_drv[k] = '0; b_drv[k] = '0; bin_drv[k] = 1'b0; iv_drv[k] = 1'b0; ordy_drv[k] = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", k, longint'(ov_mon[k]), 0);
      check("rst_D", k, d_mon[k], 0);
      check("rst_B_out", k, longint'(bo_mon[k]), 0);
      check("rst_busy", k, longint'(busy_mon[k]), 0);
      check("rst_in_ready", k, longint'(ir_mon[k]), 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_in_ready", k, longint'(ir_mon[k]), 1);
      ordy_drv[k] = 1'b1;
    end

    // Directed operand sets at WIDTH=8.
    op(1, 32'h5a, 32'h3c, 1'b0); wait_idle(1);
    op(1, 32'h00, 32'h01, 1'b0); wait_idle(1);
    op(1, 32'h80, 32'h7f, 1'b1); wait_idle(1);

    // Backpressure in DONE with noisy inputs.
    ordy_drv[1] = 1'b0;
    op(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    n = 0;
    while (!ov_mon[1] && n < 50) begin tick(1); n++; end
    for (int i = 0; i < 5; i++) begin
      a_drv[1] = $urandom; b_drv[1] = $urandom; iv_drv[1] = 1'($urandom_range(0, 1));
      check("bp_in_ready", 1, longint'(ir_mon[1]), 0);
      check("bp_out_valid", 1, longint'(ov_mon[1]), 1);
      tick(1);
    end
    ordy_drv[1] = 1'b1; iv_drv[1] = 1'b1; a_drv[1] = $urandom; b_drv[1] = $urandom;
    check("bp_release_in_ready", 1, longint'(ir_mon[1]), 0);
    tick(1);
    check("bp_idle_in_ready", 1, longint'(ir_mon[1]), 1);
    check("bp_idle_out_valid", 1, longint'(ov_mon[1]), 0);
    tick(1);
    check("bp_accept_busy", 1, longint'(busy_mon[1]), 1);
    iv_drv[1] = 1'b0;
    wait_idle(1);

    // Reset in the third SHIFT cycle aborts the operation.
    op(1, 32'h33, 32'h11, 1'b0);
    tick(1); tick(1);
    rst_n = 1'b0;
    q1.delete();
    #1;
    check("abort_out_valid", 1, longint'(ov_mon[1]), 0);
    check("abort_D", 1, d_mon[1], 0);
    check("abort_B_out", 1, longint'(bo_mon[1]), 0);
    check("abort_busy", 1, longint'(busy_mon[1]), 0);
    check("abort_in_ready", 1, longint'(ir_mon[1]), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("abort_no_out_valid", 1, longint'(ov_mon[1]), 0);
      tick(1);
    end
    op(1, 32'h10, 32'h01, 1'b0); wait_idle(1);

    // Back-to-back with in_valid and out_ready tied high.
    a_drv[1] = 32'hff; b_drv[1] = 32'hff; bin_drv[1] = 1'b1; iv_drv[1] = 1'b1;
    nacc = 0;
    for (int i = 0; i < 40 && nacc < 3; i++) begin
      if (ir_mon[1]) begin stamp[nacc] = i; nacc++; end
      tick(1);
    end
    iv_drv[1] = 1'b0;
    check("b2b_accepts", 1, nacc, 3);
    if (nacc == 3) begin
      check("b2b_period_1", 1, stamp[1] - stamp[0], 10);
      check("b2b_period_2", 1, stamp[2] - stamp[1], 10);
    end
    wait_idle(1);

    // Random regression on all three widths in parallel.
    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    tick(1);
    for (int k = 0; k < 3; k++) check("final_queue_empty", k, q_size(k), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit unsigned subtractor with borrow-in and borrow-out. It is the subtracting counterpart to the team's ripple adder cells. It accepts operands A and B through a valid/ready handshake and processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It returns D = A − B − B_in and the final borrow through a second valid/ready handshake. It serves area-constrained datapaths in the MSI component set where one result per WIDTH+2 cycles is sufficient.

## Interface
- WIDTH, 8, operand and result width in bits; legal for WIDTH ≥ 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B and B_in are presented.
- in_ready  out  1  block can accept operands; high only in IDLE, forced 0 while rst_n is low.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- B_in  in  1  borrow in.
- out_valid  out  1  D and B_out are valid.
- out_ready  in  1  consumer accepts the result.
- D  out  WIDTH  difference.
- B_out  out  1  borrow out.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, load A and B into shift registers, load borrow←B_in, clear count, clear D, then go to SHIFT.
  - SHIFT: each cycle the full_subtractor cell computes:
    - d = a0 ^ b0 ^ br
    - bo = (~a0 & b0) | (~(a0 ^ b0) & br)
  - SHIFT register updates each cycle:
    - shift A and B right by one;
    - shift the result register right, inserting d at the MSB;
    - borrow←bo; count+1.
  - SHIFT exit: when count == WIDTH−1, go to DONE.
  - DONE: out_valid=1. D is the result register and B_out is the borrow register. On out_ready, go to IDLE.
- Arithmetic:
  - D = (A − B − B_in) mod 2^WIDTH.
  - B_out = 1 iff A < B + B_in (unsigned compare, with the right side computed in WIDTH+1 bits).
- Operands are sampled only on the acceptance edge. Changes on A, B or B_in during SHIFT or DONE have no effect.
- D and B_out hold stable from the rise of out_valid until the output handshake.
- D and B_out are not cleared on exit from DONE; they keep the last result until the next acceptance.
- In DONE, in_valid is ignored even when out_ready=1 in the same cycle. There is no bypass; the next operand is accepted no earlier than the following cycle, in IDLE.
- Reset mid-operation: the operation is aborted and every register goes to its reset value immediately. out_valid is never raised for the aborted operation.
- Counter width is clog2(WIDTH)+1.

## Timing
- Reset values: state=IDLE, out_valid=0, D=0, B_out=0, busy=0. in_ready=0 while rst_n=0 and 1 after release.
- Acceptance at edge T0. Shifts occur on edges T1…T_WIDTH. out_valid rises after edge T_WIDTH, i.e. WIDTH cycles after acceptance.
- With out_ready held at 1:
  - output handshake at edge T_WIDTH+1;
  - next acceptance at edge T_WIDTH+2 at the earliest;
  - throughput is one result per WIDTH+2 cycles.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to out_valid, D or B_out. in_ready depends only on state and rst_n.

## Structure
- Shared package msi_pkg holds the state encoding localparams: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- Sub-module full_subtractor (inputs A, B, B_in; outputs D, B_out) is purely combinational and instantiated once. It is gate-level, matching the primitive style of the existing adder cells.
- The top level contains the FSM, two WIDTH-bit operand shift registers, the result shift register, the borrow flop and the counter.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, B_in=0 → D=0x1E, B_out=0, out_valid rises exactly 8 cycles after acceptance.
- A=0x00, B=0x01, B_in=0 → D=0xFF, B_out=1. A=0x80, B=0x7F, B_in=1 → D=0x00, B_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling A/B/in_valid. Required response:
  - D and B_out stay stable, in_ready stays 0, nothing is accepted;
  - after out_ready=1 the block is in IDLE next cycle and accepts on the following cycle.
- Reset asserted at the 3rd SHIFT cycle → all outputs return to reset values asynchronously and out_valid never rises. After release, A=0x10, B=0x01, B_in=0 → D=0x0F, B_out=0.
- Back-to-back with in_valid=1 and out_ready=1 tied high: A=0xFF, B=0xFF, B_in=1 repeated → D=0xFF, B_out=1 each time, one result every 10 cycles.
- Random regression over 1000 operand triples at WIDTH=1, 8 and 13 against the reference model (A−B−B_in) mod 2^WIDTH plus borrow, with random out_ready stalls.
